// File: rtl/fft_ram_pkg.sv
// fft_ram_pkg - shared types and default sizes for the FFT working memory.
//   fft_state_t : clear-sequencer states (INIT, RUN)
//   FFT_DATA_W  : default word width
//   FFT_ADDR_W  : default address width (depth = 2**FFT_ADDR_W)
package fft_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fft_state_t;

    localparam int FFT_DATA_W = 16;
    localparam int FFT_ADDR_W = 5;

endpackage

// File: rtl/fft_ram_dp_if.sv
// fft_ram_dp_if - access bus of the FFT dual-port working memory.
//   master : clr, req_x, wr_x, addr_x, data_x out; q_x, valid_x, ready, collision in
//   slave  : mirror of master (the memory side)
interface fft_ram_dp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              clr;
    logic              req_a;
    logic              wr_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic              req_b;
    logic              wr_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] q_b;
    logic              valid_a;
    logic              valid_b;
    logic              ready;
    logic              collision;

    modport master (
        output clr, req_a, wr_a, addr_a, data_a, req_b, wr_b, addr_b, data_b,
        input  q_a, q_b, valid_a, valid_b, ready, collision
    );

    modport slave (
        input  clr, req_a, wr_a, addr_a, data_a, req_b, wr_b, addr_b, data_b,
        output q_a, q_b, valid_a, valid_b, ready, collision
    );
endinterface

// File: rtl/fft_ram_init_ctrl.sv
// fft_ram_init_ctrl - clear sequencer for the FFT working memory.
//   clk, rst  : clock, async active-high reset
//   clr       : request to re-zero the array (honoured only in RUN)
//   ready     : array initialised, accesses may be accepted
//   clr_we    : clear write enable into the array
//   clr_addr  : word currently being cleared
//
//   state | meaning
//   INIT  | zeroing one word per cycle, accesses ignored
//   RUN   | array valid, accesses accepted
module fft_ram_init_ctrl
    import fft_ram_pkg::*;
#(
    parameter int ADDR_W = FFT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    fft_state_t        state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            INIT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == '1) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_n = INIT;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = INIT;
                cnt_n   = '0;
            end
        endcase
    end

    assign ready    = (state == RUN);
    assign clr_we   = (state == INIT);
    assign clr_addr = cnt;

endmodule

// File: rtl/fft_ram_dp.sv
// fft_ram_dp - parametrised dual-port working memory for the FFT datapath.
//   clk, rst : clock, async active-high reset
//   bus      : fft_ram_dp_if.slave (clr, two symmetric read/write ports,
//              q_x/valid_x results, ready, collision)
// Build option: define FFT_RAM_OUTREG_EN to add an output register stage
// (latency 2 instead of 1).
module fft_ram_dp
    import fft_ram_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int ADDR_W = FFT_ADDR_W
) (
    input logic         clk,
    input logic         rst,
    fft_ram_dp_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    fft_ram_init_ctrl #(.ADDR_W(ADDR_W)) u_init_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.clr),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A request arriving together with clr is dropped.
    logic acc_a, acc_b, wen_a, wen_b, coll;
    assign acc_a = ready & ~bus.clr & bus.req_a;
    assign acc_b = ready & ~bus.clr & bus.req_b;
    assign wen_a = acc_a & bus.wr_a;
    assign wen_b = acc_b & bus.wr_b;
    assign coll  = wen_a & wen_b & (bus.addr_a == bus.addr_b);

    // Port A is written last so it wins on a same-address double write.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wen_b) mem[bus.addr_b] <= bus.data_b;
            if (wen_a) mem[bus.addr_a] <= bus.data_a;
        end
    end

    // Reads see the pre-edge contents, giving read-old on cross-port hits.
    logic [DATA_W-1:0] rd_a, rd_b;
    assign rd_a = bus.wr_a ? bus.data_a : mem[bus.addr_a];
    assign rd_b = bus.wr_b ? (coll ? bus.data_a : bus.data_b) : mem[bus.addr_b];

    logic [DATA_W-1:0] q1_a, q1_b;
    logic              v1_a, v1_b, c1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_a <= '0;
            q1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
            c1   <= 1'b0;
        end else begin
            if (acc_a) q1_a <= rd_a;
            if (acc_b) q1_b <= rd_b;
            v1_a <= acc_a;
            v1_b <= acc_b;
            c1   <= coll;
        end
    end

`ifdef FFT_RAM_OUTREG_EN
    logic [DATA_W-1:0] q2_a, q2_b;
    logic              v2_a, v2_b, c2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q2_a <= '0;
            q2_b <= '0;
            v2_a <= 1'b0;
            v2_b <= 1'b0;
            c2   <= 1'b0;
        end else begin
            q2_a <= q1_a;
            q2_b <= q1_b;
            v2_a <= v1_a;
            v2_b <= v1_b;
            c2   <= c1;
        end
    end

    assign bus.q_a       = q2_a;
    assign bus.q_b       = q2_b;
    assign bus.valid_a   = v2_a;
    assign bus.valid_b   = v2_b;
    assign bus.collision = c2;
`else
    assign bus.q_a       = q1_a;
    assign bus.q_b       = q1_b;
    assign bus.valid_a   = v1_a;
    assign bus.valid_b   = v1_b;
    assign bus.collision = c1;
`endif

    assign bus.ready = ready;

endmodule

// File: tb/tb_fft_ram_dp.sv
// tb_fft_ram_dp - directed self-checking bench for fft_ram_dp.
module tb_fft_ram_dp;

`ifdef FFT_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fft_ram_dp_if #(.DATA_W(16), .ADDR_W(5)) bus ();

    fft_ram_dp #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clr    = 1'b0;
        bus.req_a  = 1'b0;
        bus.wr_a   = 1'b0;
        bus.addr_a = '0;
        bus.data_a = '0;
        bus.req_b  = 1'b0;
        bus.wr_b   = 1'b0;
        bus.addr_b = '0;
        bus.data_b = '0;
    endtask

    // One access cycle on both ports, then wait out the pipeline latency.
    task automatic access(input logic ra, input logic wa, input logic [4:0] aa, input logic [15:0] da,
                          input logic rb, input logic wb, input logic [4:0] ab, input logic [15:0] db);
        bus.req_a  = ra;
        bus.wr_a   = wa;
        bus.addr_a = aa;
        bus.data_a = da;
        bus.req_b  = rb;
        bus.wr_b   = wb;
        bus.addr_b = ab;
        bus.data_b = db;
        tick();
        idle();
        repeat (LAT - 1) tick();
    endtask

    task automatic read_a(input logic [4:0] a, input logic [15:0] exp, input string tag);
        access(1'b1, 1'b0, a, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
        check({tag, "_q_a"}, 32'(bus.q_a), 32'(exp));
        check({tag, "_valid_a"}, 32'(bus.valid_a), 32'd1);
    endtask

    task automatic read_b(input logic [4:0] a, input logic [15:0] exp, input string tag);
        access(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, a, 16'h0);
        check({tag, "_q_b"}, 32'(bus.q_b), 32'(exp));
        check({tag, "_valid_b"}, 32'(bus.valid_b), 32'd1);
    endtask

    // Expect ready low for exactly 32 edges from now, then high.
    task automatic wait_init(input string tag);
        for (int i = 0; i < 32; i++) begin
            check({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
            tick();
        end
        check({tag, "_ready_high"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst = 1'b1;
        #3;
        check("rst_q_a", 32'(bus.q_a), 32'd0);
        check("rst_q_b", 32'(bus.q_b), 32'd0);
        check("rst_valid_a", 32'(bus.valid_a), 32'd0);
        check("rst_valid_b", 32'(bus.valid_b), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_collision", 32'(bus.collision), 32'd0);
        tick();
        rst = 1'b0;
        wait_init("init");

        read_a(5'd0, 16'h0000, "rd0");
        read_a(5'd17, 16'h0000, "rd17");
        read_b(5'd31, 16'h0000, "rd31");

        // write-through on A, then read back on B
        access(1'b1, 1'b1, 5'd5, 16'h1234, 1'b0, 1'b0, 5'd0, 16'h0);
        check("wt_q_a", 32'(bus.q_a), 32'h1234);
        check("wt_valid_a", 32'(bus.valid_a), 32'd1);
        read_b(5'd5, 16'h1234, "rb5");
        check("hold_q_a", 32'(bus.q_a), 32'h1234);
        check("idle_valid_a", 32'(bus.valid_a), 32'd0);

        // same-address double write: A wins, collision flagged once
        access(1'b1, 1'b1, 5'd3, 16'hAAAA, 1'b1, 1'b1, 5'd3, 16'h5555);
        check("coll_flag", 32'(bus.collision), 32'd1);
        check("coll_q_a", 32'(bus.q_a), 32'hAAAA);
        check("coll_q_b", 32'(bus.q_b), 32'hAAAA);
        tick();
        check("coll_one_cycle", 32'(bus.collision), 32'd0);
        read_a(5'd3, 16'hAAAA, "rd3");

        // different-address double write: no collision
        access(1'b1, 1'b1, 5'd10, 16'h1111, 1'b1, 1'b1, 5'd11, 16'h2222);
        check("nocoll_flag", 32'(bus.collision), 32'd0);
        check("nocoll_q_b", 32'(bus.q_b), 32'h2222);

        // cross-port read/write: reader sees the old word
        access(1'b1, 1'b1, 5'd7, 16'h0F0F, 1'b0, 1'b0, 5'd0, 16'h0);
        access(1'b1, 1'b1, 5'd7, 16'hBEEF, 1'b1, 1'b0, 5'd7, 16'h0);
        check("rdold_q_b", 32'(bus.q_b), 32'h0F0F);
        check("rdold_q_a", 32'(bus.q_a), 32'hBEEF);
        read_b(5'd7, 16'hBEEF, "rb7");

        // both ports read one address
        access(1'b1, 1'b0, 5'd11, 16'h0, 1'b1, 1'b0, 5'd11, 16'h0);
        check("rr_q_a", 32'(bus.q_a), 32'h2222);
        check("rr_q_b", 32'(bus.q_b), 32'h2222);
        check("rr_coll", 32'(bus.collision), 32'd0);

        // wr without req does nothing
        bus.wr_a = 1'b1; bus.addr_a = 5'd5; bus.data_a = 16'hDEAD;
        tick();
        idle();
        read_a(5'd5, 16'h1234, "noreq_wr");

        // clr in RUN; requests during the clr cycle and INIT are ignored,
        // and a second clr inside INIT does not restart the sequence
        bus.clr = 1'b1;
        bus.req_a = 1'b1; bus.wr_a = 1'b1; bus.addr_a = 5'd9; bus.data_a = 16'h9999;
        tick();
        bus.data_a = 16'hFFFF; bus.addr_a = 5'd0;
        for (int i = 0; i < 32; i++) begin
            bus.clr = (i == 10);
            check("clr_ready_low", 32'(bus.ready), 32'd0);
            check("clr_valid_a", 32'(bus.valid_a), 32'd0);
            tick();
        end
        idle();
        check("clr_ready_high", 32'(bus.ready), 32'd1);
        read_a(5'd0, 16'h0000, "clr_rd0");
        read_a(5'd3, 16'h0000, "clr_rd3");
        read_b(5'd5, 16'h0000, "clr_rd5");
        read_b(5'd7, 16'h0000, "clr_rd7");
        read_a(5'd9, 16'h0000, "clr_rd9");

        // rst in the middle of INIT
        access(1'b1, 1'b1, 5'd1, 16'h5A5A, 1'b1, 1'b1, 5'd2, 16'hA5A5);
        check("pre_rst_q_a", 32'(bus.q_a), 32'h5A5A);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_q_a", 32'(bus.q_a), 32'd0);
        check("mid_rst_q_b", 32'(bus.q_b), 32'd0);
        check("mid_rst_valid_a", 32'(bus.valid_a), 32'd0);
        check("mid_rst_ready", 32'(bus.ready), 32'd0);
        tick();
        rst = 1'b0;
        wait_init("reinit");
        read_a(5'd1, 16'h0000, "reinit_rd1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_ram_dp.md
# fft_ram_dp

Parametrised dual-port working memory for the FFT datapath, between the butterfly unit (data) and the address generator (addresses). It generalises the fixed 16×32 dual-port RAM with configurable width and depth, per-port access enables with output valids, a hardware clear sequence after reset or on request, and defined same-address collision handling. Both ports are fully symmetric read/write ports in one clock domain.

## Interface
- DATA_W, 16, word width (butterfly sample width)
- ADDR_W, 5, address width; depth = 2**ADDR_W words
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  one-cycle pulse: re-zero the whole array
- req_a, req_b  in  1  port access request
- wr_a, wr_b  in  1  write (1) / read (0); qualified by req_x
- addr_a, addr_b  in  ADDR_W  word address
- data_a, data_b  in  DATA_W  write data
- q_a, q_b  out  DATA_W  read data / write-through data
- valid_a, valid_b  out  1  q_x holds the result of an accepted access
- ready  out  1  array initialised; requests accepted
- collision  out  1  one-cycle flag: both ports wrote the same address

## Operation
- FSM states: INIT, RUN. Asynchronous rst → INIT, clear counter = 0.
- INIT: one word per cycle, counter 0 … 2**ADDR_W−1, each written to 0; ready = 0; req_a/req_b ignored (no write, valid stays 0). After the last word → RUN.
- RUN: ready = 1. clr in RUN → INIT, counter = 0; a request presented in the clr cycle is ignored. clr in INIT is ignored (no restart).
- Accepted access: req_x = 1 while in RUN. Write: mem[addr_x] ← data_x, q_x ← data_x (write-through). Read: q_x ← mem[addr_x].
- Cross-port read/write to the same address in the same cycle: the reader gets the old contents (read-old).
- Both ports write the same address: port A wins. Memory holds data_a, q_a = q_b = data_a, collision = 1 for one cycle.
- Both ports read the same address: both get the stored word, no flag.
- When req_x = 0, q_x holds its previous value and valid_x = 0.
- wr_x with req_x = 0 has no effect.

## Timing
- Reset values: q_a = q_b = 0, valid_a = valid_b = 0, ready = 0, collision = 0. Array contents after rst are undefined until INIT completes.
- Read/write latency: 1 cycle. Request at edge n gives q_x and valid_x after edge n+1. collision is aligned with valid.
- INIT lasts exactly 2**ADDR_W cycles. ready rises on the edge after the last clear write.
- rst mid-INIT or mid-RUN: immediate return to the reset values. INIT restarts from address 0 after rst is released.
- The last clear write and the first accepted request never share a cycle.

## Configuration
- FFT_RAM_OUTREG_EN defined: an extra output register stage on q_x, valid_x and collision. Latency is 2 cycles and the reset values are unchanged. Read-old and port-A-wins semantics are unchanged.
- Not defined: latency is 1 cycle, as above.

## Structure
- Shared package fft_ram_pkg holds:
  - the state enum {INIT, RUN}
  - default constants FFT_DATA_W = 16 and FFT_ADDR_W = 5
- Sub-module fft_ram_init_ctrl holds the FSM, clear counter, ready and clr handling. It drives the clear-write address and the enable into the array.
- Array, port muxing and collision logic live in the top module.

## Test plan
- Reset, then wait: ready = 0 for 32 cycles (default parameters) and 1 afterwards. Reads of addresses 0, 17 and 31 return 0 with valid = 1 one cycle later.
- Port A writes 0x1234 to address 5, next cycle port B reads address 5 → q_b = 0x1234 and valid_b = 1 after 1 cycle. Also q_a = 0x1234 in the write cycle plus 1.
- Same cycle: port A writes 0xAAAA to address 3 and port B writes 0x5555 to address 3 → collision = 1 for one cycle and q_a = q_b = 0xAAAA. A later read of address 3 returns 0xAAAA.
- Address 7 holds 0x0F0F; in one cycle A writes 0xBEEF to address 7 while B reads address 7 → q_b = 0x0F0F. The next read of address 7 returns 0xBEEF.
- clr in RUN after data is written → ready drops for 32 cycles and requests are ignored (valid = 0). All addresses then read 0.
- rst asserted midway through INIT (cycle 10) → outputs return to reset values at once. After release, INIT runs a full 32 cycles before ready = 1.
- With FFT_RAM_OUTREG_EN defined, the second scenario gives q_b and valid_b 2 cycles after the request.
